// File: rtl/ping_responder.sv
// ping_responder: transponder end of the phase-ping ranging link.
//
// Watches the RF receive strobe for a ping burst and qualifies it by edge
// count. After a fixed turnaround it keys the transmitter for one reply burst,
// then blanks its own receiver for a holdoff interval. The latency from the
// last received edge to the first tx_en cycle is always GAP_MAX + 1 + TURN_DLY,
// so the initiator can subtract it from the measured round trip.
//
// Ports:
//   clk        in   system clock (48 MHz)
//   rst        in   asynchronous active-high reset
//   arm        in   enables detection; low aborts detection and turnaround
//   rx_stb     in   one-cycle strobe per received RF edge
//   tx_en      out  transmitter key, high for exactly BURST_LEN cycles per reply
//   busy       out  high whenever the responder is not idle
//   ping_seen  out  one-cycle pulse when a ping is accepted
//   last_edges out  edge count of the most recently accepted ping (saturates at 255)
//   reply_cnt  out  number of replies started, wraps modulo 2^16
module ping_responder #(
  parameter int DET_MIN   = 4,
  parameter int GAP_MAX   = 16,
  parameter int TURN_DLY  = 100,
  parameter int BURST_LEN = 64,
  parameter int HOLDOFF   = 200,
  parameter int CW        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic        rx_stb,
  output logic        tx_en,
  output logic        busy,
  output logic        ping_seen,
  output logic [7:0]  last_edges,
  output logic [15:0] reply_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    DETECT,
    TURN,
    REPLY,
    HOLD
  } state_t;

  // Each timer counts 0..N-1 inside its state, so the terminal value is N-1.
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_MAX - 1);
  localparam logic [CW-1:0] TURN_LAST  = CW'(TURN_DLY - 1);
  localparam logic [CW-1:0] BURST_LAST = CW'(BURST_LEN - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLDOFF - 1);
  localparam logic [7:0]    DET_MIN8   = 8'(DET_MIN);

  state_t        state, state_nx;
  logic [CW-1:0] timer, timer_nx;
  logic [7:0]    edges, edges_nx;
  logic          tx_en_nx;
  logic          ping_seen_nx;
  logic [7:0]    last_edges_nx;
  logic [15:0]   reply_cnt_nx;

  always_comb begin
    state_nx      = state;
    timer_nx      = timer;
    edges_nx      = edges;
    tx_en_nx      = 1'b0;
    ping_seen_nx  = 1'b0;
    last_edges_nx = last_edges;
    reply_cnt_nx  = reply_cnt;

    case (state)
      IDLE: begin
        timer_nx = '0;
        edges_nx = '0;
        if (arm && rx_stb) begin
          state_nx = DETECT;
          edges_nx = 8'd1;
        end
      end

      DETECT: begin
        if (!arm) begin
          state_nx = IDLE;
          timer_nx = '0;
          edges_nx = '0;
        end else if (rx_stb) begin
          // An edge in the expiry cycle still extends the burst.
          timer_nx = '0;
          if (edges != 8'hFF) edges_nx = edges + 8'd1;
        end else if (timer == GAP_LAST) begin
          timer_nx = '0;
          edges_nx = '0;
          if (edges >= DET_MIN8) begin
            state_nx      = TURN;
            last_edges_nx = edges;
            ping_seen_nx  = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          timer_nx = timer + 1'b1;
        end
      end

      TURN: begin
        if (!arm) begin
          state_nx = IDLE;
          timer_nx = '0;
        end else if (timer == TURN_LAST) begin
          state_nx     = REPLY;
          timer_nx     = '0;
          tx_en_nx     = 1'b1;
          reply_cnt_nx = reply_cnt + 16'd1;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end

      // arm is deliberately ignored: a reply burst is never truncated.
      REPLY: begin
        if (timer == BURST_LAST) begin
          state_nx = HOLD;
          timer_nx = '0;
        end else begin
          tx_en_nx = 1'b1;
          timer_nx = timer + 1'b1;
        end
      end

      // Receiver blanking window; rx_stb and arm are both ignored here.
      HOLD: begin
        if (timer == HOLD_LAST) begin
          state_nx = IDLE;
          timer_nx = '0;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end

      default: begin
        state_nx = IDLE;
        timer_nx = '0;
        edges_nx = '0;
      end
    endcase
  end

  // Outputs are registered from next-state values so they line up with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      edges      <= '0;
      tx_en      <= 1'b0;
      busy       <= 1'b0;
      ping_seen  <= 1'b0;
      last_edges <= '0;
      reply_cnt  <= '0;
    end else begin
      state      <= state_nx;
      timer      <= timer_nx;
      edges      <= edges_nx;
      tx_en      <= tx_en_nx;
      busy       <= (state_nx != IDLE);
      ping_seen  <= ping_seen_nx;
      last_edges <= last_edges_nx;
      reply_cnt  <= reply_cnt_nx;
    end
  end

endmodule

// File: doc/ping_responder.md
Name: ping_responder

Overview:
- Transponder end of the phase-ping ranging link.
- Watches the digitized RF receive strobe for an incoming ping burst and qualifies it by edge count.
- After a fixed, deterministic turnaround it keys the transmitter for a reply burst, then blanks its own receiver for a holdoff interval.
- Sits between the rf receive strobe (rf_rx_stb) and the tx block's tx_en input on the remote board. Turnaround is cycle-exact so the initiator can subtract it from measured round-trip time.

Parameters:
- DET_MIN, 4: minimum rx_stb edges in one burst for the burst to count as a ping (1..255).
- GAP_MAX, 16: cycles with no rx_stb that end a burst (≥1).
- TURN_DLY, 100: cycles from end of burst detection to start of reply (≥1).
- BURST_LEN, 64: cycles tx_en is held high (≥1).
- HOLDOFF, 200: cycles after the reply during which rx_stb is ignored (≥1).
- CW, 16: internal timer width; must hold the maximum of GAP_MAX, TURN_DLY, BURST_LEN and HOLDOFF.

Ports:
- clk, input, 1: system clock, 48 MHz.
- rst, input, 1: reset, asynchronous, active-high.
- arm, input, 1: enables detection; low aborts detection and turnaround.
- rx_stb, input, 1: one-cycle strobe per received RF edge.
- tx_en, output, 1: transmitter key; high for exactly BURST_LEN cycles per reply.
- busy, output, 1: high whenever state is not IDLE.
- ping_seen, output, 1: one-cycle pulse on ping acceptance.
- last_edges, output, 8: edge count of the most recently accepted ping.
- reply_cnt, output, 16: number of replies started; wraps modulo 2^16.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-burst):
  - state = IDLE.
  - tx_en, busy, ping_seen = 0.
  - last_edges = 0, reply_cnt = 0.
  - Internal edge count and timer = 0.
- All outputs are registered.
- States: IDLE, DETECT, TURN, REPLY, HOLD.
- IDLE:
  - If arm && rx_stb in cycle t0: go to DETECT at t0+1, with edge count = 1 and timer = 0.
  - rx_stb with arm low is ignored.
- DETECT:
  - Cycle with rx_stb: edge count += 1, saturating at 255; timer = 0.
  - Cycle without rx_stb: timer += 1.
  - When the timer reaches GAP_MAX (last edge at cycle tL, decision at cycle tL+GAP_MAX):
    - If edge count ≥ DET_MIN: go to TURN, latch last_edges = edge count, timer = 0.
    - Otherwise go to IDLE (reject); no output changes.
  - rx_stb in the same cycle the timer would expire: the edge wins, the timer resets and the burst continues.
  - arm low in any DETECT cycle: go to IDLE next cycle.
- TURN:
  - ping_seen = 1 in the first TURN cycle only (cycle tL+GAP_MAX+1).
  - Lasts exactly TURN_DLY cycles, then REPLY.
  - rx_stb is ignored.
  - arm low: go to IDLE next cycle; no reply is sent and reply_cnt is not incremented.
- REPLY:
  - First REPLY cycle is tL+GAP_MAX+1+TURN_DLY; tx_en is high in exactly that cycle and the following BURST_LEN-1 cycles.
  - reply_cnt increments once, on REPLY entry.
  - arm is ignored; a burst is never truncated except by rst.
  - rx_stb is ignored.
- HOLD:
  - Begins the cycle after the last tx_en cycle, with tx_en = 0.
  - Lasts HOLDOFF cycles, then IDLE.
  - rx_stb is ignored, which suppresses self-echo.
  - arm low does not shorten HOLD.
- Cycle budget:
  - Total reply latency from the last received edge to the first tx_en cycle = GAP_MAX + 1 + TURN_DLY; this is a fixed constant for the initiator.
  - A new ping can be detected no earlier than HOLDOFF cycles after tx_en falls.
- Widths:
  - Timers compare with ==; the CW width must not overflow.
  - reply_cnt wraps from 65535 to 0 without a flag.
  - The edge counter saturates, and last_edges reports 255 for long bursts.

Test Plan (defaults):
- **Accept:** arm=1; 6 rx_stb, one every 4 cycles, last at cycle 100 → ping_seen pulses at cycle 117; tx_en high in cycles 217..280; last_edges=6; reply_cnt=1; busy falls after cycle 480.
- **Reject:** 3 rx_stb spaced 4 cycles apart → DETECT returns to IDLE 16 cycles after the last edge; ping_seen, tx_en and reply_cnt stay 0.
- **Gap boundary:** edges 15 cycles apart continue the burst. An edge arriving in the expiry cycle (16 cycles after the previous one) also continues it. A 17-cycle gap splits the burst, and each half is rejected if it has fewer than 4 edges.
- **Blanking:** rx_stb injected during TURN, REPLY and HOLD has no effect. A valid ping starting 1 cycle after HOLD ends is accepted with the same latency.
- **Arm abort:**
  - arm dropped mid-TURN → no tx_en, reply_cnt unchanged.
  - arm dropped mid-REPLY → tx_en stays high for the full 64 cycles.
- **Reset and wrap:**
  - rst asserted mid-REPLY → tx_en and busy go low with no clock edge.
  - reply_cnt preloaded via 65536 replies (or forced) wraps to 0.
  - A 300-edge burst gives last_edges=255.
